// File: rtl/cnn_pkg.sv
// Shared constants, FSM state type and flat-bus slicing helpers for the
// first CNN convolution stage.
`timescale 1ns/1ps
package cnn_pkg;
  localparam int N_FILT    = 6;
  localparam int N_TAP     = 25;
  localparam int W_W       = 9;
  localparam int ACC_W     = 23;
  localparam int OUT_W     = 16;
  localparam int FRAME_LEN = 259;
  localparam int W_BITS    = N_FILT * N_TAP * W_W;
  localparam int B_BITS    = N_FILT * W_W;

  typedef enum logic [1:0] {SNAP, MAC, BIAS, SEND} state_t;

  // Tap n = f*25 + r*5 + c is packed MSB-first in the weight bus.
  function automatic int w_off(input int n);
    return W_BITS - 1 - W_W * n;
  endfunction

  function automatic int b_off(input int f);
    return B_BITS - 1 - W_W * f;
  endfunction
endpackage

// File: rtl/cnn_mac.sv
// Signed 9-bit tap times unsigned 8-bit pixel, accumulated into a signed
// 23-bit register with synchronous clear (clear wins over enable).
`timescale 1ns/1ps
module cnn_mac
  import cnn_pkg::*;
(
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  logic signed [W_W-1:0]   i_w,
  input  logic        [7:0]       i_x,
  output logic signed [ACC_W-1:0] o_acc
);
  logic signed [17:0]      w_prod;
  logic signed [ACC_W-1:0] r_acc;

  assign w_prod = i_w * $signed({1'b0, i_x});
  assign o_acc  = r_acc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + {{(ACC_W-18){w_prod[17]}}, w_prod};
    end
  end
endmodule

// File: rtl/cnn.sv
// Six-filter 5x5 convolution over a constant patch; each result passes
// bias, ReLU and 16-bit saturation, then leaves serially behind a start bit.
`timescale 1ns/1ps
module cnn
  import cnn_pkg::*;
#(
  parameter logic [7:0] PIXEL = 8'd1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [W_BITS-1:0] weights,
  input  logic [B_BITS-1:0] bias,
  output logic              data
);
  state_t                  r_state;
  state_t                  w_state_next;
  logic [W_BITS-1:0]       r_w;
  logic [B_BITS-1:0]       r_b;
  logic [2:0]              r_f;
  logic [4:0]              r_t;
  logic [OUT_W-1:0]        r_sh;
  logic                    r_data;
  logic                    w_clr;
  logic                    w_en;
  logic [7:0]              w_idx;
  logic signed [W_W-1:0]   w_tap;
  logic signed [W_W-1:0]   w_bias;
  logic signed [ACC_W-1:0] w_acc;
  logic signed [ACC_W:0]   w_sum;
  logic [OUT_W-1:0]        w_result;

  assign w_idx  = 8'(r_f) * 8'(N_TAP) + 8'(r_t);
  assign w_tap  = r_w[w_off(int'(w_idx)) -: W_W];
  assign w_bias = r_b[b_off(int'(r_f)) -: W_W];
  assign data   = r_data;

  cnn_mac u_mac (
    .clk   (clk),
    .rstn  (rstn),
    .i_clr (w_clr),
    .i_en  (w_en),
    .i_w   (w_tap),
    .i_x   (PIXEL),
    .o_acc (w_acc)
  );

  // One extra bit of headroom so the bias add can never wrap.
  assign w_sum = {w_acc[ACC_W-1], w_acc} + {{(ACC_W+1-W_W){w_bias[W_W-1]}}, w_bias};

  always_comb begin
    w_result = w_sum[OUT_W-1:0];
    if (w_sum[ACC_W]) begin
      w_result = '0;
    end else if (|w_sum[ACC_W-1:OUT_W]) begin
      w_result = '1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= SNAP;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_clr        = 1'b0;
    w_en         = 1'b0;
    case (r_state)
      SNAP: begin
        w_clr        = 1'b1;
        w_state_next = MAC;
      end
      MAC: begin
        w_en = 1'b1;
        if (r_t == 5'(N_TAP - 1)) w_state_next = BIAS;
      end
      BIAS: begin
        w_clr        = 1'b1;
        w_state_next = SEND;
      end
      SEND: begin
        if (r_t == 5'(OUT_W)) w_state_next = (r_f == 3'(N_FILT - 1)) ? SNAP : MAC;
      end
      default: w_state_next = SNAP;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_w    <= '0;
      r_b    <= '0;
      r_f    <= '0;
      r_t    <= '0;
      r_sh   <= '0;
      r_data <= 1'b0;
    end else begin
      r_data <= 1'b0;
      case (r_state)
        SNAP: begin
          r_w <= weights;
          r_b <= bias;
          r_f <= '0;
          r_t <= '0;
        end
        MAC: begin
          r_t <= (r_t == 5'(N_TAP - 1)) ? 5'd0 : r_t + 5'd1;
        end
        BIAS: begin
          r_sh <= w_result;
          r_t  <= '0;
        end
        SEND: begin
          // Slot 0 is the start bit; slots 1..16 shift the word out MSB first.
          r_data <= (r_t == 5'd0) ? 1'b1 : r_sh[OUT_W-1];
          if (r_t != 5'd0) r_sh <= {r_sh[OUT_W-2:0], 1'b0};
          if (r_t == 5'(OUT_W)) begin
            r_t <= '0;
            if (r_f != 3'(N_FILT - 1)) r_f <= r_f + 3'd1;
          end else begin
            r_t <= r_t + 5'd1;
          end
        end
        default: r_t <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_cnn.sv
// Self-checking bench: two instances (PIXEL=1 and PIXEL=255) checked bit by
// bit against an arithmetic model of the convolution and the frame timeline.
`timescale 1ns/1ps
module tb_cnn;
  import cnn_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic [1349:0] weights;
  logic [53:0]   bias;
  logic          data_a;
  logic          data_b;

  cnn #(.PIXEL(8'd1)) dut_a (
    .clk(clk), .rstn(rstn), .weights(weights), .bias(bias), .data(data_a)
  );
  cnn #(.PIXEL(8'd255)) dut_b (
    .clk(clk), .rstn(rstn), .weights(weights), .bias(bias), .data(data_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int wt[6][25];
  int bs[6];
  int sel;
  logic [15:0] exp_a[6], exp_b[6], cap_a[6], cap_b[6];

  function automatic logic [15:0] model_word(input int f, input int pix);
    int s;
    s = bs[f];
    for (int t = 0; t < 25; t++) s += wt[f][t] * pix;
    if (s < 0) s = 0;
    if (s > 65535) s = 65535;
    return 16'(s);
  endfunction

  task automatic apply();
    for (int n = 0; n < 150; n++) weights[1349-9*n -: 9] = 9'(wt[n/25][n%25]);
    for (int f = 0; f < 6; f++) bias[53-9*f -: 9] = 9'(bs[f]);
  endtask

  task automatic set_all(input int w, input int b);
    for (int f = 0; f < 6; f++) begin
      bs[f] = b;
      for (int t = 0; t < 25; t++) wt[f][t] = w;
    end
    apply();
  endtask

  task automatic set_random();
    for (int f = 0; f < 6; f++) begin
      bs[f] = int'($urandom_range(0, 511)) - 256;
      for (int t = 0; t < 25; t++) wt[f][t] = int'($urandom_range(0, 511)) - 256;
    end
    apply();
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: model snapshot before a SNAP edge, then sample #1 after the edge.
  task automatic tick();
    int p, q, f, r;
    logic ea, eb;
    if (rstn && (cyc % FRAME_LEN == 0)) begin
      for (int k = 0; k < 6; k++) begin
        exp_a[k] = model_word(k, 1);
        exp_b[k] = model_word(k, 255);
        cap_a[k] = '0;
        cap_b[k] = '0;
      end
    end
    @(posedge clk);
    #1;
    ea = 1'b0;
    eb = 1'b0;
    if (rstn) begin
      p = cyc % FRAME_LEN;
      if (p != 0) begin
        q = p - 1;
        f = q / 43;
        r = q % 43;
        if (r == 26) begin
          ea = 1'b1;
          eb = 1'b1;
        end else if (r >= 27) begin
          ea = exp_a[f][42-r];
          eb = exp_b[f][42-r];
          cap_a[f] = {cap_a[f][14:0], data_a};
          cap_b[f] = {cap_b[f][14:0], data_b};
        end
      end
      cyc++;
    end
    chk1("data_a", data_a, ea);
    chk1("data_b", data_b, eb);
  endtask

  task automatic run_frame();
    repeat (FRAME_LEN) tick();
  endtask

  task automatic check_model_words(input string tag);
    for (int f = 0; f < 6; f++) begin
      chk16({tag, "_a"}, cap_a[f], exp_a[f]);
      chk16({tag, "_b"}, cap_b[f], exp_b[f]);
    end
  endtask

  initial begin
    rstn = 1'b0;
    set_all(1, 0);
    repeat (3) tick();
    rstn = 1'b1;
    cyc  = 0;

    // Unit weights, zero bias: 25 per word at PIXEL=1.
    run_frame();
    for (int f = 0; f < 6; f++) chk16("ones_a", cap_a[f], 16'h0019);
    check_model_words("ones");

    // One filter all -1 with bias +5 clamps to zero; the rest stay 25.
    sel = int'($urandom_range(0, 5));
    for (int t = 0; t < 25; t++) wt[sel][t] = -1;
    bs[sel] = 5;
    apply();
    run_frame();
    for (int f = 0; f < 6; f++) chk16("relu_a", cap_a[f], (f == sel) ? 16'h0000 : 16'h0019);
    check_model_words("relu");

    // Maximum positive taps and bias saturate at PIXEL=255.
    set_all(255, 255);
    run_frame();
    for (int f = 0; f < 6; f++) begin
      chk16("sat_b", cap_b[f], 16'hFFFF);
      chk16("sat_a", cap_a[f], 16'h19E6);
    end

    // Per-filter distinct words 2f+1, over two consecutive frames.
    set_all(0, 0);
    for (int f = 0; f < 6; f++) begin
      wt[f][0] = f + 1;
      bs[f]    = f;
    end
    apply();
    repeat (2) begin
      run_frame();
      for (int f = 0; f < 6; f++) chk16("dist_a", cap_a[f], 16'(2 * f + 1));
      check_model_words("dist");
    end

    // Weights change at E100 take effect only from the next frame.
    set_random();
    repeat (101) tick();
    set_random();
    repeat (FRAME_LEN - 101) tick();
    check_model_words("mid_old");
    run_frame();
    check_model_words("mid_new");

    repeat (3) begin
      set_random();
      run_frame();
      check_model_words("rand");
    end

    // E70 carries filter 1's start bit, so the asynchronous clear is visible.
    set_all(1, 0);
    repeat (71) tick();
    #2 rstn = 1'b0;
    #1;
    chk1("async_clr_a", data_a, 1'b0);
    chk1("async_clr_b", data_b, 1'b0);
    repeat (3) tick();
    rstn = 1'b1;
    cyc  = 0;
    run_frame();
    for (int f = 0; f < 6; f++) chk16("rst_a", cap_a[f], 16'h0019);
    check_model_words("rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
